// File: rtl/hex_keypad_reader.sv
`default_nettype none
// ============================================================================
// Module   : hex_keypad_reader
// Purpose  : Scans a 4x4 hex keypad (one column driven low at a time), samples
//            the active-low rows, debounces whole-matrix frames and shifts each
//            accepted key nibble into a 3-digit value. The 13-bit hex_value has
//            the same layout as the 7-segment display driver's input.
// Ports    : clk       - system clock
//            rst       - synchronous, active-high reset
//            cols[3:0] - column drives, active low, exactly one bit low
//            rows[3:0] - row sense lines, active low, asynchronous
//            key_valid - one-cycle pulse per accepted key
//            key_code  - nibble of the last accepted key
//            hex_value - [11:0] last three digits (newest in [3:0]),
//                        [12] set once three or more digits were entered
// Revision : 1.0 - initial release
// ============================================================================
module hex_keypad_reader #(
    parameter int SCAN_RATE       = 1000,       // Hz per column
    parameter int SYS_CLK_FREQ    = 100000000,  // Hz
    parameter int DEBOUNCE_FRAMES = 4           // 1..255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  cols,
    input  logic [3:0]  rows,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [12:0] hex_value
);

    // Column dwell in clocks; must be at least 4 so the synchronised rows
    // reflect the currently driven column when the dwell ends.
    localparam int          c_col_div  = SYS_CLK_FREQ / (SCAN_RATE * 4);
    localparam logic [31:0] c_div_last = 32'(c_col_div - 1);
    localparam logic [7:0]  c_deb      = 8'(DEBOUNCE_FRAMES);

    // Frame classes
    localparam logic [1:0] c_cls_none  = 2'd0;
    localparam logic [1:0] c_cls_key   = 2'd1;
    localparam logic [1:0] c_cls_multi = 2'd2;

    typedef enum logic [0:0] {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_div;
    logic [1:0]  r_col_idx;
    logic [3:0]  r_cols;
    logic [3:0]  r_rows_meta;
    logic [3:0]  r_rows_sync;
    logic [3:0]  r_samp0;
    logic [3:0]  r_samp1;
    logic [3:0]  r_samp2;
    logic [1:0]  r_cand_kind;
    logic [3:0]  r_cand_key;
    logic [7:0]  r_cnt;
    logic [1:0]  r_digits;
    logic        r_key_valid;
    logic [3:0]  r_key_code;
    logic [12:0] r_hex_value;

    logic        w_tick;
    logic [1:0]  w_col_next;
    logic [3:0]  w_cols_next;
    logic [3:0]  w_col_rows [0:3];
    logic [1:0]  w_hits;
    logic [3:0]  w_hit_idx;
    logic [1:0]  w_cls_kind;
    logic [3:0]  w_cls_key;
    logic        w_same;
    logic [7:0]  w_next_cnt;
    logic        w_qual;

    // Position index is row*4 + column.
    function automatic logic [3:0] keymap(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:  v = 4'h1;
            4'd1:  v = 4'h2;
            4'd2:  v = 4'h3;
            4'd3:  v = 4'hA;
            4'd4:  v = 4'h4;
            4'd5:  v = 4'h5;
            4'd6:  v = 4'h6;
            4'd7:  v = 4'hB;
            4'd8:  v = 4'h7;
            4'd9:  v = 4'h8;
            4'd10: v = 4'h9;
            4'd11: v = 4'hC;
            4'd12: v = 4'h0;
            4'd13: v = 4'hF;
            4'd14: v = 4'hE;
            default: v = 4'hD;
        endcase
        return v;
    endfunction

    assign w_tick     = (r_div == c_div_last);
    assign w_col_next = r_col_idx + 2'd1;

    always_comb begin
        w_cols_next = 4'b1111;
        w_cols_next[w_col_next] = 1'b0;
    end

    // The col3 rows are taken straight from the synchroniser so the frame is
    // classified on the same tick that ends it.
    always_comb begin
        w_col_rows[0] = r_samp0;
        w_col_rows[1] = r_samp1;
        w_col_rows[2] = r_samp2;
        w_col_rows[3] = r_rows_sync;
    end

    // Count low intersections (saturating at 2) and remember the last one.
    always_comb begin
        w_hits    = 2'd0;
        w_hit_idx = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!w_col_rows[c][r]) begin
                    if (w_hits != 2'd2) begin
                        w_hits = w_hits + 2'd1;
                    end
                    w_hit_idx = 4'(r * 4 + c);
                end
            end
        end
    end

    always_comb begin
        w_cls_kind = c_cls_none;
        w_cls_key  = 4'd0;
        if (w_hits == 2'd1) begin
            w_cls_kind = c_cls_key;
            w_cls_key  = keymap(w_hit_idx);
        end else if (w_hits == 2'd2) begin
            w_cls_kind = c_cls_multi;
        end
    end

    always_comb begin
        w_same     = (w_cls_kind == r_cand_kind) && (w_cls_key == r_cand_key);
        w_next_cnt = 8'd1;
        if (w_same) begin
            w_next_cnt = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
        end
        w_qual = (w_next_cnt == c_deb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RELEASED;
            r_div       <= 32'd0;
            r_col_idx   <= 2'd0;
            r_cols      <= 4'b1110;
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
            r_samp0     <= 4'hF;
            r_samp1     <= 4'hF;
            r_samp2     <= 4'hF;
            r_cand_kind <= c_cls_none;
            r_cand_key  <= 4'd0;
            r_cnt       <= 8'd0;
            r_digits    <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_hex_value <= 13'd0;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
            r_key_valid <= 1'b0;

            if (w_tick) begin
                r_div     <= 32'd0;
                r_col_idx <= w_col_next;
                r_cols    <= w_cols_next;

                case (r_col_idx)
                    2'd0:    r_samp0 <= r_rows_sync;
                    2'd1:    r_samp1 <= r_rows_sync;
                    2'd2:    r_samp2 <= r_rows_sync;
                    default: ;
                endcase

                if (r_col_idx == 2'd3) begin
                    // MULTI only refreshes the candidate; it can never
                    // satisfy either transition below.
                    r_cand_kind <= w_cls_kind;
                    r_cand_key  <= w_cls_key;
                    r_cnt       <= w_next_cnt;

                    case (r_state)
                        ST_RELEASED: begin
                            if ((w_cls_kind == c_cls_key) && w_qual) begin
                                r_state     <= ST_PRESSED;
                                r_key_valid <= 1'b1;
                                r_key_code  <= w_cls_key;
                                r_hex_value[11:0] <= {r_hex_value[7:0], w_cls_key};
                                if (r_digits != 2'd3) begin
                                    r_digits <= r_digits + 2'd1;
                                end
                                if (r_digits >= 2'd2) begin
                                    r_hex_value[12] <= 1'b1;
                                end
                            end
                        end
                        ST_PRESSED: begin
                            // A different stable key is ignored until a
                            // qualified release (no rollover).
                            if ((w_cls_kind == c_cls_none) && w_qual) begin
                                r_state <= ST_RELEASED;
                            end
                        end
                        default: r_state <= ST_RELEASED;
                    endcase
                end
            end else begin
                r_div <= r_div + 32'd1;
            end
        end
    end

    assign cols      = r_cols;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign hex_value = r_hex_value;

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_keypad_reader
// Purpose  : Bench for hex_keypad_reader. A keypad model drives rows from the
//            pressed-key set and the DUT's column drives. Each expected accept
//            is queued when the press is driven and compared when key_valid
//            pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_reader;

    localparam int SYS_CLK_FREQ    = 4000;
    localparam int SCAN_RATE       = 250;
    localparam int DEBOUNCE_FRAMES = 2;
    localparam int COL_DIV         = SYS_CLK_FREQ / (SCAN_RATE * 4);
    localparam int FRAME           = 4 * COL_DIV;
    // Frame-aligned press: the pulse lands in cycle index DEB*FRAME counted
    // from the first cycle of the press (i.e. the 33rd cycle here).
    localparam int LATENCY         = DEBOUNCE_FRAMES * FRAME;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [12:0] hex_value;

    logic [15:0] pressed = 16'd0;   // bit index row*4 + column
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [3:0]  code;
        logic [12:0] hex;
        int          at_cyc;        // -1: timing not checked
    } exp_t;

    exp_t        sb_q [$];
    logic [12:0] m_hex;
    int          m_digits;

    hex_keypad_reader #(
        .SCAN_RATE       (SCAN_RATE),
        .SYS_CLK_FREQ    (SYS_CLK_FREQ),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cols      (cols),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .hex_value (hex_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int key_pos(input logic [3:0] x);
        case (x)
            4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
            4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
            4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
            4'h0: return 12;  4'hF: return 13;  4'hE: return 14;  default: return 15;
        endcase
    endfunction

    function automatic logic [15:0] key_bit(input logic [3:0] x);
        logic [15:0] v;
        v = 16'd0;
        v[key_pos(x)] = 1'b1;
        return v;
    endfunction

    task automatic expect_accept(input logic [3:0] x, input int at);
        exp_t e;
        m_hex[11:0] = {m_hex[7:0], x};
        m_digits++;
        if (m_digits >= 3) m_hex[12] = 1'b1;
        e.code   = x;
        e.hex    = m_hex;
        e.at_cyc = at;
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            check_val("pulse_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("pulse_key_code", 32'(key_code), 32'(e.code));
                check_val("pulse_hex_value", 32'(hex_value), 32'(e.hex));
                if (e.at_cyc >= 0) check_val("pulse_latency", cyc, e.at_cyc);
            end
        end
    end

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    // Returns at the negedge of the first cycle of a fresh frame.
    task automatic do_reset();
        pressed = 16'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_hex = 13'd0;
        m_digits = 0;
        sb_q.delete();
    endtask

    task automatic enter_key(input logic [3:0] x, input logic [12:0] want);
        pressed = key_bit(x);
        expect_accept(x, -1);
        frames(4);
        pressed = 16'd0;
        frames(4);
        check_val("entry_hex_value", 32'(hex_value), 32'(want));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout cycles=%0d limit=200000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  exp_cols;
        logic [3:0]  seq_keys [0:3];
        logic [12:0] seq_hex  [0:3];
        int          t0;

        seq_keys = '{4'h1, 4'hA, 4'h0, 4'hD};
        seq_hex  = '{13'h0001, 13'h001A, 13'h11A0, 13'h1A0D};

        // Reset values and idle column scan.
        do_reset();
        check_val("rst_cols", 32'(cols), 32'hE);
        check_val("rst_key_valid", 32'(key_valid), 32'd0);
        check_val("rst_key_code", 32'(key_code), 32'd0);
        check_val("rst_hex_value", 32'(hex_value), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            repeat (COL_DIV) @(negedge clk);
            exp_cols = 4'b1111;
            exp_cols[i % 4] = 1'b0;
            check_val("scan_cols", 32'(cols), 32'(exp_cols));
        end
        frames(2);
        check_val("idle_hex_value", 32'(hex_value), 32'd0);

        // Frame-aligned hold of key 5: one pulse, fixed latency, no repeat.
        do_reset();
        t0 = cyc;
        pressed = key_bit(4'h5);
        expect_accept(4'h5, t0 + LATENCY);
        frames(4);
        check_val("hold5_key_code", 32'(key_code), 32'h5);
        check_val("hold5_hex_value", 32'(hex_value), 32'h0005);
        pressed = 16'd0;
        frames(4);
        check_val("hold5_drained", sb_q.size(), 0);

        // Digit entry 1, A, 0, D.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enter_key(seq_keys[i], seq_hex[i]);
        end
        check_val("entry_drained", sb_q.size(), 0);

        // Key 7 bouncing in alternate frames, then a held 7 with one glitch.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? key_bit(4'h7) : 16'd0;
            frames(1);
        end
        pressed = 16'd0;
        frames(2);
        check_val("bounce_hex_value", 32'(hex_value), 32'd0);
        check_val("bounce_key_code", 32'(key_code), 32'd0);
        pressed = key_bit(4'h7);
        expect_accept(4'h7, cyc + LATENCY);
        frames(3);
        pressed = 16'd0;
        frames(1);
        pressed = key_bit(4'h7);
        frames(3);
        pressed = 16'd0;
        frames(4);
        check_val("glitch_hex_value", 32'(hex_value), 32'h0007);
        check_val("glitch_drained", sb_q.size(), 0);

        // Keys 2 and 8 together, then 8 released while 2 stays down.
        do_reset();
        pressed = key_bit(4'h2) | key_bit(4'h8);
        frames(4);
        check_val("multi_key_code", 32'(key_code), 32'd0);
        check_val("multi_hex_value", 32'(hex_value), 32'd0);
        pressed = key_bit(4'h2);
        expect_accept(4'h2, cyc + LATENCY);
        frames(4);
        pressed = 16'd0;
        frames(4);
        check_val("multi_then2_hex", 32'(hex_value), 32'h0002);
        check_val("multi_drained", sb_q.size(), 0);

        // Reset during the second qualifying frame of key C.
        do_reset();
        pressed = key_bit(4'hC);
        frames(1);
        repeat (FRAME / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hex = 13'd0;
        m_digits = 0;
        check_val("midrst_cols", 32'(cols), 32'hE);
        check_val("midrst_key_valid", 32'(key_valid), 32'd0);
        check_val("midrst_key_code", 32'(key_code), 32'd0);
        check_val("midrst_hex_value", 32'(hex_value), 32'd0);
        expect_accept(4'hC, cyc + LATENCY);
        frames(4);
        pressed = 16'd0;
        frames(4);
        check_val("midrst_final_hex", 32'(hex_value), 32'h000C);
        check_val("final_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
